jpeg_bitstream_unstuffer: RTL and testbench

//  Receive side of the JPEG encoder output interface. Accepts 32-bit MSB-first

---
 rtl/jpeg_bitstream_unstuffer_if.sv | 41 ++++
 rtl/jpeg_bitstream_unstuffer.sv | 188 ++++++++++++++++++
 tb/tb_jpeg_bitstream_unstuffer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bitstream_unstuffer_if.sv
// Word-in / byte-out bus of the JPEG bitstream unstuffer.
// Handshakes:
//   input side  : a word is taken on a rising edge where
//                 (data_ready | eof_data_partial_ready) & in_ready.
//   output side : out_byte is transferred on a rising edge where
//                 out_valid & out_ready; out_byte/out_valid hold while stalled.
//   marker_valid / stream_done are single-cycle pulses with no handshake.
interface jpeg_bitstream_unstuffer_if #(
  parameter int NUM_BYTES = 4
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(W);

  logic [W-1:0]  JPEG_bitstream;
  logic          data_ready;
  logic          eof_data_partial_ready;
  logic [CW-1:0] end_of_file_bitstream_count;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          marker_valid;
  logic [7:0]    marker_code;
  logic          stream_done;

  // Environment side: produces words, consumes bytes.
  modport master (
    output JPEG_bitstream, data_ready, eof_data_partial_ready,
           end_of_file_bitstream_count, out_ready,
    input  in_ready, out_byte, out_valid, marker_valid, marker_code,
           stream_done
  );

  // Unstuffer side.
  modport slave (
    input  JPEG_bitstream, data_ready, eof_data_partial_ready,
           end_of_file_bitstream_count, out_ready,
    output in_ready, out_byte, out_valid, marker_valid, marker_code,
           stream_done
  );
endinterface

// File: rtl/jpeg_bitstream_unstuffer.sv
// JPEG bitstream unstuffer: takes MSB-first entropy-coded words, removes the
// 0x00 stuffed after each 0xFF, splits out FFxx markers, and emits a byte
// stream. A pending FF survives word boundaries; a partial word ends the
// stream, flushing a dangling FF and pulsing stream_done.
module jpeg_bitstream_unstuffer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  jpeg_bitstream_unstuffer_if.slave   bus,
  output logic [1:0]                  dbg_state
);
  localparam int W   = 8 * NUM_BYTES;
  localparam int CW  = $clog2(W);
  localparam int NBW = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   word_q;
  logic           partial_q;
  logic [CW-1:0]  cnt_q;
  logic [NBW-1:0] nb_q;
  logic [NBW-1:0] idx_q, idx_d;
  logic           ff_pending_q, pend_d;

  logic [7:0]     out_byte_q;
  logic           out_valid_q;
  logic           marker_valid_q;
  logic [7:0]     marker_code_q;
  logic           stream_done_q;

  logic           in_ready;
  logic           take;
  logic           out_free;
  logic [W-1:0]   shifted;
  logic [7:0]     cur_byte;
  logic           last_byte;
  logic [CW:0]    cnt_ext;
  logic [NBW-1:0] nb_calc;
  logic [W-1:0]   fill_word;

  logic           emit;
  logic [7:0]     emit_val;
  logic           mark;
  logic [7:0]     mark_code;
  logic           done_pulse;

  // in_ready is gated by reset so it stays low while reset is held.
  assign in_ready   = (state_q == IDLE) & rst;
  assign take       = (bus.data_ready | bus.eof_data_partial_ready) & in_ready;
  assign out_free   = ~out_valid_q | bus.out_ready;
  assign shifted    = word_q << {idx_q, 3'b000};
  assign cur_byte   = shifted[W-1 -: 8];
  assign last_byte  = ((idx_q + NBW'(1)) == nb_q);

  assign bus.in_ready     = in_ready;
  assign bus.out_byte     = out_byte_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.marker_valid = marker_valid_q;
  assign bus.marker_code  = marker_code_q;
  assign bus.stream_done  = stream_done_q;
  assign dbg_state        = state_q;

  // Byte count of the buffered word and JPEG 1-fill of the last partial byte.
  always_comb begin
    cnt_ext   = {1'b0, cnt_q} + (CW+1)'(7);
    nb_calc   = partial_q ? NBW'(cnt_ext >> 3) : NBW'(NUM_BYTES);
    fill_word = word_q;
    if (partial_q && (cnt_q[2:0] != 3'd0)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if ((NBW'(i) + NBW'(1)) == nb_calc) begin
          fill_word[W-1-8*i -: 8] = word_q[W-1-8*i -: 8] | (8'hFF >> cnt_q[2:0]);
        end
      end
    end
  end

  // Next state and per-byte unstuffing decision.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = ff_pending_q;
    emit       = 1'b0;
    emit_val   = 8'h00;
    mark       = 1'b0;
    mark_code  = 8'h00;
    done_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) state_d = LOAD;
      end
      LOAD: begin
        idx_d   = '0;
        state_d = (partial_q && (nb_calc == '0)) ? DONE : UNLOAD;
      end
      UNLOAD: begin
        if (out_free) begin
          if (!ff_pending_q) begin
            if (cur_byte == 8'hFF) begin
              pend_d = 1'b1;
            end else begin
              emit     = 1'b1;
              emit_val = cur_byte;
            end
          end else begin
            if (cur_byte == 8'h00) begin
              emit     = 1'b1;
              emit_val = 8'hFF;
              pend_d   = 1'b0;
            end else if (cur_byte != 8'hFF) begin
              mark      = 1'b1;
              mark_code = cur_byte;
              pend_d    = 1'b0;
            end
          end
          idx_d = idx_q + NBW'(1);
          if (last_byte) state_d = partial_q ? DONE : IDLE;
        end
      end
      DONE: begin
        // A dangling FF at end of stream is data; flush it before finishing.
        if (out_free) begin
          if (ff_pending_q) begin
            emit     = 1'b1;
            emit_val = 8'hFF;
            pend_d   = 1'b0;
          end else begin
            done_pulse = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, byte index and pending-FF flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ff_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ff_pending_q <= pend_d;
    end
  end

  // Word buffer: captured on accept, fill applied and byte count fixed in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q    <= '0;
      partial_q <= 1'b0;
      cnt_q     <= '0;
      nb_q      <= '0;
    end else if (take) begin
      word_q    <= bus.JPEG_bitstream;
      partial_q <= bus.eof_data_partial_ready;
      cnt_q     <= bus.eof_data_partial_ready ? bus.end_of_file_bitstream_count : '0;
    end else if (state_q == LOAD) begin
      word_q <= fill_word;
      nb_q   <= nb_calc;
    end
  end

  // Registered outputs: byte register held under backpressure, pulses 1 cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_byte_q     <= 8'h00;
      out_valid_q    <= 1'b0;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      stream_done_q  <= 1'b0;
    end else begin
      if (emit) begin
        out_byte_q  <= emit_val;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      marker_valid_q <= mark;
      if (mark) marker_code_q <= mark_code;
      stream_done_q <= done_pulse;
    end
  end
endmodule

// File: tb/tb_jpeg_bitstream_unstuffer.sv
// Bench for jpeg_bitstream_unstuffer: directed scenarios plus randomized
// words, checked against a byte-level reference model via queues.
module tb_jpeg_bitstream_unstuffer;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  jpeg_bitstream_unstuffer_if #(.NUM_BYTES(4)) bus ();

  jpeg_bitstream_unstuffer #(.NUM_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_m_q[$];
  int         exp_done;
  bit         model_pend;
  int         n_cmp;
  int         n_bad;
  int         ready_mode;   // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte list of the word, JPEG fill on the last partial byte,
  // then FF/00 unstuffing and marker extraction with a carried pending flag.
  task automatic model_word(input logic [31:0] w, input bit part, input int cnt);
    int nb;
    int r;
    logic [7:0] b;
    nb = part ? (cnt + 7) / 8 : 4;
    r  = cnt % 8;
    for (int i = 0; i < nb; i++) begin
      b = w[31 - 8*i -: 8];
      if (part && (i == nb - 1) && (r != 0)) b = b | 8'((1 << (8 - r)) - 1);
      if (!model_pend) begin
        if (b == 8'hFF) model_pend = 1;
        else exp_q.push_back(b);
      end else if (b == 8'h00) begin
        exp_q.push_back(8'hFF);
        model_pend = 0;
      end else if (b != 8'hFF) begin
        exp_m_q.push_back(b);
        model_pend = 0;
      end
    end
    if (part) begin
      if (model_pend) begin
        exp_q.push_back(8'hFF);
        model_pend = 0;
      end
      exp_done++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w, input bit part, input int cnt, input bit both);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    if (!bus.in_ready) return;
    model_word(w, part, cnt);
    bus.JPEG_bitstream              = w;
    bus.data_ready                  = !part || both;
    bus.eof_data_partial_ready      = part;
    bus.end_of_file_bitstream_count = part ? 5'(cnt) : 5'd0;
    @(posedge clk);
    #1;
    bus.data_ready             = 1'b0;
    bus.eof_data_partial_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp_m_q.size() != 0 || exp_done != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_bytes", exp_q.size(), 0);
    chk("drain_markers", exp_m_q.size(), 0);
    chk("drain_done", exp_done, 0);
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 9))
      0, 1, 2: return 8'hFF;
      3, 4:    return 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // out_ready driver, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit         prev_hold;
  logic [7:0] prev_byte;
  initial begin
    prev_hold = 0;
    prev_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("hold_byte", {24'd0, bus.out_byte}, {24'd0, prev_byte});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.out_byte}, 32'h100);
          else chk("byte", {24'd0, bus.out_byte}, {24'd0, exp_q.pop_front()});
        end
        if (bus.marker_valid) begin
          if (exp_m_q.size() == 0) chk("unexpected_marker", {24'd0, bus.marker_code}, 32'h100);
          else chk("marker_code", {24'd0, bus.marker_code}, {24'd0, exp_m_q.pop_front()});
        end
        if (bus.stream_done) begin
          chk("done_expected", {31'd0, exp_done > 0}, 32'd1);
          chk("done_after_bytes", exp_q.size(), 0);
          if (exp_done > 0) exp_done--;
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_byte = bus.out_byte;
      end
    end
  end

  // Run-time bound.
  initial begin
    #600000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    bit part;
    n_cmp = 0;
    n_bad = 0;
    exp_done = 0;
    model_pend = 0;
    ready_mode = 0;
    bus.JPEG_bitstream = '0;
    bus.data_ready = 1'b0;
    bus.eof_data_partial_ready = 1'b0;
    bus.end_of_file_bitstream_count = '0;

    // Reset state.
    rst = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_marker_valid", {31'd0, bus.marker_valid}, 32'd0);
    chk("rst_stream_done", {31'd0, bus.stream_done}, 32'd0);
    chk("rst_out_byte", {24'd0, bus.out_byte}, 32'd0);
    chk("rst_marker_code", {24'd0, bus.marker_code}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Stuffed FF inside one word, with first-byte latency.
    send_word(32'h12FF0034, 0, 0, 0);
    @(negedge clk);
    chk("lat_n1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_n2", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_n3", {31'd0, bus.out_valid}, 32'd1);
    wait_drain();
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Stuffing across a word boundary.
    send_word(32'hAABBCCFF, 0, 0, 0);
    send_word(32'h00112233, 0, 0, 0);
    wait_drain();

    // Marker with preceding fill FF.
    send_word(32'h5AFFFFD9, 0, 0, 0);
    wait_drain();

    // Partial words: fill bits, empty partial, dangling FF, both strobes.
    send_word(32'hABC00000, 1, 12, 0);
    wait_drain();
    send_word(32'h00000000, 1, 0, 0);
    wait_drain();
    send_word(32'h12FF0000, 1, 16, 1);
    wait_drain();
    send_word(32'h31415926, 1, 31, 0);
    wait_drain();

    // Backpressure mid-word.
    send_word(32'h11223344, 0, 0, 0);
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out_byte", {24'd0, bus.out_byte}, 32'h22);
    end
    ready_mode = 0;
    wait_drain();

    // Reset while unloading with an FF pending.
    send_word(32'hFFFF0011, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_marker_valid", {31'd0, bus.marker_valid}, 32'd0);
    chk("arst_stream_done", {31'd0, bus.stream_done}, 32'd0);
    chk("arst_out_byte", {24'd0, bus.out_byte}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    exp_q.delete();
    exp_m_q.delete();
    exp_done = 0;
    model_pend = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    send_word(32'h00112233, 0, 0, 0);
    wait_drain();

    // Randomized words with random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      part = ($urandom_range(0, 4) == 0);
      send_word({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, part,
                part ? int'($urandom_range(0, 31)) : 0, bit'($urandom_range(0, 1)));
    end
    send_word(32'h00000000, 1, 0, 0);
    wait_drain();
    ready_mode = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
